// File: rtl/smg_scan_ctrl_if.sv
// Load channel between the digit-producing logic and the scan controller:
// new digit/dp content offered under Load_Req, acknowledged by Load_Ack.
interface smg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 6
);
  logic [4*DIGITS-1:0] Digit_In;
  logic [DIGITS-1:0]   Dp_In;
  logic                Load_Req;
  logic                Load_Ack;

  modport master (output Digit_In, Dp_In, Load_Req, input Load_Ack);
  modport slave  (input Digit_In, Dp_In, Load_Req, output Load_Ack);
endinterface

// File: rtl/smg_scan_ctrl.sv
// Common-anode seven-segment scanner: SHOW/BLANK per digit, double-buffered
// content swapped only at the frame boundary, leading-zero and dp handling.
module smg_scan_ctrl #(
  parameter int unsigned DIGITS  = 6,
  parameter logic [19:0] T_SHOW  = 20'd49_999,
  parameter logic [19:0] T_BLANK = 20'd2_499
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Lz_En,
  smg_scan_ctrl_if.slave    load_if,
  output logic [7:0]        Row_Scan_Sig,
  output logic [DIGITS-1:0] Column_Scan_Sig
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {SHOW, BLANK} state_t;

  state_t              state_q, state_d;
  logic [19:0]         cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] buf_q, buf_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                ack_q, ack_d;
  logic [7:0]          row_q, row_d;
  logic [DIGITS-1:0]   col_q, col_d;

  logic                frame_end;
  logic                nz_above;
  logic [3:0]          cur_digit;
  logic [7:0]          seg;

  function automatic logic [7:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 8'hC0;
      4'd1:    decode = 8'hF9;
      4'd2:    decode = 8'hA4;
      4'd3:    decode = 8'hB0;
      4'd4:    decode = 8'h99;
      4'd5:    decode = 8'h92;
      4'd6:    decode = 8'h82;
      4'd7:    decode = 8'hF8;
      4'd8:    decode = 8'h80;
      4'd9:    decode = 8'h90;
      default: decode = 8'hFF;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 20'd1;
    idx_d     = idx_q;
    buf_d     = buf_q;
    dp_d      = dp_q;
    ack_d     = 1'b0;
    frame_end = (state_q == BLANK) && (cnt_q == T_BLANK) && (idx_q == IW'(DIGITS - 1));

    case (state_q)
      SHOW: begin
        if (cnt_q == T_SHOW) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == T_BLANK) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
      end
    endcase

    if (frame_end && load_if.Load_Req) begin
      buf_d = load_if.Digit_In;
      dp_d  = load_if.Dp_In;
      ack_d = 1'b1;
    end

    // Suppression looks at the live buffer and Lz_En, so it needs no boundary.
    nz_above = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i >= 32'(idx_q) && buf_q[i*4 +: 4] != 4'd0) nz_above = 1'b1;
    end

    cur_digit = buf_q[{idx_q, 2'b00} +: 4];
    seg       = decode(cur_digit);
    if (Lz_En && (idx_q != '0) && !nz_above) seg[6:0] = '1;
    seg[7]    = ~dp_q[idx_q];

    if (state_q == SHOW) begin
      row_d = seg;
      col_d = ~(DIGITS'(1) << idx_q);
    end else begin
      row_d = '1;
      col_d = '1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      dp_q    <= '0;
      ack_q   <= 1'b0;
      row_q   <= '1;
      col_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      dp_q    <= dp_d;
      ack_q   <= ack_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign load_if.Load_Ack = ack_q;
  assign Row_Scan_Sig     = row_q;
  assign Column_Scan_Sig  = col_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Bench for smg_scan_ctrl: reference model derived from elapsed ticks since reset.
module tb_smg_scan_ctrl;
  localparam int unsigned ND    = 4;
  localparam int unsigned TS    = 3;
  localparam int unsigned TBL   = 1;
  localparam int unsigned SLOT  = TS + TBL + 2;
  localparam int unsigned FRAME = ND * SLOT;
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lz;
  logic [7:0] row;
  logic [3:0] col;

  smg_scan_ctrl_if #(.DIGITS(ND)) lif ();

  smg_scan_ctrl #(
    .DIGITS (ND),
    .T_SHOW (20'(TS)),
    .T_BLANK(20'(TBL))
  ) dut (
    .CLK            (clk),
    .RST_n          (rst_n),
    .Lz_En          (lz),
    .load_if        (lif),
    .Row_Scan_Sig   (row),
    .Column_Scan_Sig(col)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned t;
  logic [15:0] mbuf;
  logic [3:0]  mdp;
  logic        last_ack;
  int unsigned ack_ticks[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (tick %0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    return (v < 4'd10) ? SEG[v] : 8'hFF;
  endfunction

  // Called at a negedge; drives inputs, checks the outputs after the next posedge.
  task automatic step(input logic req, input logic [15:0] din, input logic [3:0] dp,
                      input logic lzv);
    int unsigned p, d;
    logic [7:0]  er;
    logic [3:0]  ec;
    logic        ea;
    lif.Load_Req = req;
    lif.Digit_In = din;
    lif.Dp_In    = dp;
    lz           = lzv;
    p = t % SLOT;
    d = (t / SLOT) % ND;
    if (p <= TS) begin
      er = seg_of(mbuf[d*4 +: 4]);
      if (lzv && d > 0 && (mbuf >> (4*d)) == 16'd0) er[6:0] = 7'h7F;
      if (mdp[d]) er[7] = 1'b0;
      ec = ~(4'b0001 << d);
    end else begin
      er = 8'hFF;
      ec = 4'hF;
    end
    ea = ((t % FRAME) == FRAME - 1) && req;
    @(posedge clk);
    #1;
    check("row", row, er);
    check("col", col, ec);
    check("ack", lif.Load_Ack, ea);
    check("col_onehot", ($countones(~col) <= 1), 1'b1);
    last_ack = lif.Load_Ack;
    if (last_ack) ack_ticks.push_back(t);
    if (ea) begin
      mbuf = din;
      mdp  = dp;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n, input logic lzv);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 16'h0000, 4'h0, lzv);
  endtask

  task automatic load(input logic [15:0] din, input logic [3:0] dp, input logic lzv);
    logic got;
    got = 1'b0;
    for (int unsigned i = 0; i < 2*FRAME + 4 && !got; i++) begin
      step(1'b1, din, dp, lzv);
      got = last_ack;
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  task automatic align(input int unsigned ph, input logic lzv);
    while ((t % FRAME) != ph) step(1'b0, 16'h0000, 4'h0, lzv);
  endtask

  task automatic do_reset_init();
    t    = 0;
    mbuf = '0;
    mdp  = '0;
  endtask

  initial begin
    logic        rq, lzr;
    logic [15:0] dr;
    logic [3:0]  pr;

    rst_n        = 1'b0;
    lz           = 1'b0;
    lif.Load_Req = 1'b0;
    lif.Digit_In = '0;
    lif.Dp_In    = '0;
    last_ack     = 1'b0;
    do_reset_init();
    #12;
    check("rst_row", row, 8'hFF);
    check("rst_col", col, 4'hF);
    check("rst_ack", lif.Load_Ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_reset_init();

    idle(30, 1'b0);
    load(16'h1234, 4'b0100, 1'b0);
    idle(30, 1'b0);
    load(16'h0070, 4'b0000, 1'b1);
    idle(30, 1'b1);
    load(16'h0000, 4'b0000, 1'b1);
    idle(30, 1'b1);
    load(16'h1020, 4'b0000, 1'b1);
    for (int unsigned i = 0; i < 2*FRAME; i++) step(1'b0, 16'h0, 4'h0, ((i / 7) % 2) == 1);

    // Short request away from the boundary must not capture.
    align(5, 1'b0);
    ack_ticks.delete();
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 16'h9999, 4'hF, 1'b0);
    idle(30, 1'b0);
    check("pulse_no_ack", ack_ticks.size(), 0);

    // Request held for three frames: three separate captures.
    align(0, 1'b0);
    ack_ticks.delete();
    for (int unsigned i = 0; i < 3*FRAME; i++) step(1'b1, 16'(4321 + i), 4'(i), 1'b0);
    check("held_ack_count", ack_ticks.size(), 3);
    if (ack_ticks.size() == 3) begin
      check("held_ack_gap1", ack_ticks[1] - ack_ticks[0], FRAME);
      check("held_ack_gap2", ack_ticks[2] - ack_ticks[1], FRAME);
    end
    idle(30, 1'b0);

    load(16'h0B00, 4'b0100, 1'b1);
    idle(30, 1'b1);

    // Asynchronous reset while digit 2 is being shown.
    align(13, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_row", row, 8'hFF);
    check("midrst_col", col, 4'hF);
    check("midrst_ack", lif.Load_Ack, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_reset_init();
    idle(2*FRAME, 1'b0);

    rq  = 1'b0;
    lzr = 1'b0;
    dr  = '0;
    pr  = '0;
    for (int unsigned i = 0; i < 1000*FRAME; i++) begin
      if (rq) rq = ($urandom_range(0, 2) != 0);
      else    rq = ($urandom_range(0, 9) == 0);
      if (!rq || $urandom_range(0, 7) == 0) begin
        for (int unsigned k = 0; k < ND; k++)
          dr[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        pr = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) lzr = ~lzr;
      step(rq, dr, pr, lzr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
